// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status lines of the boot loader.
// The master side is the loader itself; the slave side is the host/memory environment.
interface imem_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed byte stream -> big-endian words,
// with length and checksum verification before the CPU is released.
module imem_loader #(
  parameter int          MEM_WORDS      = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

  function automatic logic is_active(input logic [2:0] st);
    return (st == S_LEN_HI) || (st == S_LEN_LO) || (st == S_DATA) || (st == S_CHECK);
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_next_s;
  logic [15:0]      len_r;
  logic [15:0]      word_idx_r;
  logic [1:0]       byte_idx_r;
  logic [31:0]      asm_r;
  logic [7:0]       chk_r;
  logic [TMO_W-1:0] tmo_r;

  logic             mem_we_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic             cpu_hold_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;

  logic             active_s;
  logic             start_ok_s;
  logic             accept_s;
  logic             tmo_hit_s;
  logic             word_end_s;
  logic             last_word_s;
  logic             len_bad_s;
  logic [15:0]      len_s;
  logic [31:0]      word_s;

  // Input qualification; bytes outside an active load (including one coincident with start) are dropped.
  always_comb begin
    active_s    = is_active(state_r);
    start_ok_s  = bus.start && !active_s;
    accept_s    = active_s && bus.rx_valid;
    tmo_hit_s   = active_s && !accept_s && (tmo_r == TMO_LAST);
    len_s       = {len_r[15:8], bus.rx_data};
    len_bad_s   = (len_s == 16'd0) || (32'(len_s) > 32'(MEM_WORDS));
    word_end_s  = accept_s && (state_r == S_DATA) && (byte_idx_r == 2'd3);
    last_word_s = (word_idx_r == (len_r - 16'd1));
    word_s      = {asm_r[23:0], bus.rx_data};
  end

  // Next-state logic of the load FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) state_next_s = S_LEN_HI;
        else           state_next_s = state_r;
      end
      S_LEN_HI: begin
        if (accept_s)       state_next_s = S_LEN_LO;
        else if (tmo_hit_s) state_next_s = S_ERROR;
        else                state_next_s = state_r;
      end
      S_LEN_LO: begin
        if (accept_s) begin
          if (len_bad_s) state_next_s = S_ERROR;
          else           state_next_s = S_DATA;
        end else if (tmo_hit_s) begin
          state_next_s = S_ERROR;
        end else begin
          state_next_s = state_r;
        end
      end
      S_DATA: begin
        if (word_end_s && last_word_s) state_next_s = S_CHECK;
        else if (tmo_hit_s)            state_next_s = S_ERROR;
        else                           state_next_s = state_r;
      end
      S_CHECK: begin
        if (accept_s) begin
          if (bus.rx_data == chk_r) state_next_s = S_DONE;
          else                      state_next_s = S_ERROR;
        end else if (tmo_hit_s) begin
          state_next_s = S_ERROR;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register and status outputs, registered from the next state so they track it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cpu_hold_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      busy_r     <= is_active(state_next_s);
      cpu_hold_r <= is_active(state_next_s) || (state_next_s == S_ERROR);
      done_r     <= (state_next_s == S_DONE);
      err_r      <= (state_next_s == S_ERROR);
    end
  end

  // Inter-byte timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_r <= '0;
    end else if (start_ok_s || accept_s || !active_s) begin
      tmo_r <= '0;
    end else begin
      tmo_r <= tmo_r + TMO_W'(1);
    end
  end

  // Frame length, word assembly, byte/word indices and running checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r      <= 16'd0;
      word_idx_r <= 16'd0;
      byte_idx_r <= 2'd0;
      asm_r      <= 32'd0;
      chk_r      <= 8'd0;
    end else if (start_ok_s) begin
      len_r      <= 16'd0;
      word_idx_r <= 16'd0;
      byte_idx_r <= 2'd0;
      asm_r      <= 32'd0;
      chk_r      <= 8'd0;
    end else if (accept_s) begin
      case (state_r)
        S_LEN_HI: len_r[15:8] <= bus.rx_data;
        S_LEN_LO: len_r[7:0]  <= bus.rx_data;
        S_DATA: begin
          asm_r      <= word_s;
          chk_r      <= chk_add(chk_r, bus.rx_data);
          byte_idx_r <= byte_idx_r + 2'd1;
          if (byte_idx_r == 2'd3) word_idx_r <= word_idx_r + 16'd1;
          else                    word_idx_r <= word_idx_r;
        end
        default: len_r <= len_r;
      endcase
    end else begin
      len_r <= len_r;
    end
  end

  // Memory write port: one-cycle pulse the cycle after a word's last byte; address/data hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= BASE_ADDR;
      mem_wdata_r <= 32'd0;
    end else if (word_end_s) begin
      mem_we_r    <= 1'b1;
      mem_addr_r  <= BASE_ADDR + {14'd0, word_idx_r, 2'b00};
      mem_wdata_r <= word_s;
    end else begin
      mem_we_r    <= 1'b0;
    end
  end

  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.cpu_hold  = cpu_hold_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory.
- Receives a framed byte stream (typically from the UART receiver), assembles big-endian 32-bit words and writes them to consecutive word addresses of the instruction memory write port.
- Holds the CPU in reset while loading.
- Releases the CPU only after a length-checked and checksum-verified image has been written.

Parameters:
- MEM_WORDS, 256, capacity of instruction memory in words; legal image length is 1..MEM_WORDS.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (word aligned).
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes while loading before aborting.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse.
- mem_addr  output  32  byte address of the write (word aligned).
- mem_wdata  output  32  write data.
- cpu_hold  output  1  holds the CPU in reset while high.
- busy  output  1  load in progress.
- done  output  1  last load succeeded (sticky).
- err  output  1  last load failed (sticky).

Behaviour:
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, MSB first.
  - 4N payload bytes; each word is MSB byte first.
  - CHK byte: sum of all 4N payload bytes modulo 256. Length bytes are excluded from the sum.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- Reset (asynchronous): state IDLE. mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0. All counters, the checksum and the timeout counter are cleared.
- start:
  - Accepted in IDLE, DONE or ERROR: next state LEN_HI. done and err cleared; checksum, word index and byte index cleared.
  - Ignored in LEN_HI..CHECK.
  - If start and rx_valid arrive in the same cycle, the byte is discarded.
- rx_valid is ignored in IDLE, DONE and ERROR.
- busy=1 and cpu_hold=1 in LEN_HI, LEN_LO, DATA and CHECK.
- LEN_LO:
  - On a byte, latch N.
  - If N==0 or N>MEM_WORDS, go to ERROR; otherwise go to DATA.
- DATA:
  - A 2-bit byte index shifts each byte into the assembly register (left shift by 8) and adds it to the 8-bit checksum (wrap-around).
  - On the 4th byte of a word, in the following cycle: mem_we=1 for exactly one cycle, mem_wdata=assembled word, mem_addr=BASE_ADDR+4*word_index.
  - word_index then increments. After word N-1 is written, the next state is CHECK.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- CHECK:
  - On a byte: if it equals the checksum, go to DONE; else go to ERROR.
  - Memory is not rolled back on error.
- DONE: done=1, cpu_hold=0, busy=0.
- ERROR: err=1, cpu_hold=1 (a bad image never runs), busy=0. Leaving ERROR requires start or reset.
- Timeout:
  - Counter clears on every accepted byte and on entry to LEN_HI.
  - Counts every other cycle in LEN_HI..CHECK.
  - When it reaches TIMEOUT_CYCLES-1, the next state is ERROR.
- Back-to-back bytes (rx_valid on consecutive cycles) are fully supported. A write pulse may coincide with the next byte's acceptance.
- Reset mid-load aborts immediately: no further mem_we, outputs return to reset values.

Test Plan:
- Reset -> all outputs at reset values; rx_valid pulses in IDLE -> no mem_we and state unchanged.
- start, then bytes 00 02 3c 04 40 00 24 84 00 0c 34 ->
  - mem_we at addr 0x0 with data 0x3c044000, one cycle after the 6th byte;
  - mem_we at addr 0x4 with data 0x2484000c;
  - then done=1, cpu_hold=0, err=0.
- Same frame with checksum byte 35 -> both words written, err=1, cpu_hold=1, done=0; a subsequent start clears err and busy=1.
- Length bytes 00 00, and separately 01 01 (257 > 256) -> err=1 immediately after LEN_LO, no mem_we.
- With TIMEOUT_CYCLES=16: start, 00 01 3c, then silence -> err=1 after 16 idle cycles; assert reset mid-frame in a second run -> outputs reset and no write.
- start coincident with rx_valid -> that byte is discarded. start pulses during DATA -> ignored and the load completes normally.
